// File: rtl/imem_loadable_if.sv
// rtl/imem_loadable_if.sv - fetch and program-load signal bundle for imem_loadable
interface imem_loadable_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    // fetch port
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_stall;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic            if_fault;

    // loader port
    logic            ld_start;
    logic            ld_valid;
    logic [XLEN-1:0] ld_data;
    logic            ld_last;
    logic            ld_ready;
    logic            ld_done;
    logic [CW-1:0]   ld_count;

    modport master (
        output if_req, if_addr, if_stall, ld_start, ld_valid, ld_data, ld_last,
        input  if_valid, if_instr, if_fault, ld_ready, ld_done, ld_count
    );

    modport slave (
        input  if_req, if_addr, if_stall, ld_start, ld_valid, ld_data, ld_last,
        output if_valid, if_instr, if_fault, ld_ready, ld_done, ld_count
    );
endinterface

// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - loadable instruction memory with registered fetch port
module imem_loadable #(
    parameter int              XLEN  = 32,
    parameter int              DEPTH = 64,
    parameter int              AW    = 32,
    parameter logic [XLEN-1:0] NOP   = XLEN'(32'h00000013)
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_loadable_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wptr_q, wptr_d;      // also the loaded-word count
    logic            done_q, done_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] mem [0:DEPTH-1];

    logic            accept;
    logic            load_end;
    logic            load_enter;
    logic [IW-1:0]   idx;
    logic            addr_fault;

    assign idx        = bus.if_addr[IW+1:2];
    assign addr_fault = (bus.if_addr[1:0] != 2'b00) || ((bus.if_addr >> (IW + 2)) != '0);

    assign bus.if_valid = valid_q;
    assign bus.if_instr = instr_q;
    assign bus.if_fault = fault_q;
    assign bus.ld_done  = done_q;
    assign bus.ld_count = wptr_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a load ends on ld_last or when the array fills
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.ld_start) state_d = S_LOAD;
            S_LOAD:  if (load_end)     state_d = S_RUN;
            S_RUN:   if (bus.ld_start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: loader handshake decoded from state and write pointer
    always_comb begin
        bus.ld_ready = (state_q == S_LOAD) && (wptr_q < CW'(DEPTH));
        accept       = bus.ld_ready && bus.ld_valid;
        load_end     = accept && (bus.ld_last || (wptr_q == CW'(DEPTH - 1)));
        load_enter   = (state_q != S_LOAD) && bus.ld_start;
    end

    // write pointer restarts on LOAD entry, done pulses on the final accepted word
    always_comb begin
        wptr_d = wptr_q;
        if (load_enter) begin
            wptr_d = '0;
        end else if (accept) begin
            wptr_d = wptr_q + CW'(1);
        end
        done_d = load_end;
    end

    // fetch response: stall holds, outside RUN the core spins on NOPs
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        fault_d = fault_q;
        if (!bus.if_stall) begin
            valid_d = bus.if_req;
            if (bus.if_req) begin
                if (state_q != S_RUN) begin
                    instr_d = NOP;
                    fault_d = 1'b0;
                end else if (addr_fault) begin
                    instr_d = NOP;
                    fault_d = 1'b1;
                end else if ({1'b0, idx} < wptr_q) begin
                    instr_d = mem[idx];
                    fault_d = 1'b0;
                end else begin
                    instr_d = NOP;
                    fault_d = 1'b0;
                end
            end
        end
    end

    // control and fetch output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= NOP;
            fault_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // storage array, not reset: validity lives in the word count
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr_q[IW-1:0]] <= bus.ld_data;
        end
    end
endmodule

// File: tb/tb_imem_loadable.sv
// tb/tb_imem_loadable.sv - self-checking bench for imem_loadable
module tb_imem_loadable;
    localparam int          XLEN  = 32;
    localparam int          DEPTH = 64;
    localparam int          AW    = 32;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    imem_loadable_if #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) bus();

    imem_loadable #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: mode 0=idle 1=load 2=run, program held as a queue
    int          m_mode;
    logic [31:0] prog[$];
    logic        e_valid, e_fault, e_done;
    logic [31:0] e_instr;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
    } fvec_t;
    fvec_t tbl [0:7];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.if_stall = 1'b0;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic model_reset();
        m_mode  = 0;
        prog.delete();
        e_valid = 1'b0;
        e_instr = NOP;
        e_fault = 1'b0;
        e_done  = 1'b0;
    endtask

    // advance model by one clock from the current inputs, then clock the DUT
    task automatic tick();
        logic [31:0] a;
        a = bus.if_addr;
        if (!bus.if_stall) begin
            e_valid = bus.if_req;
            if (bus.if_req) begin
                if (m_mode != 2) begin
                    e_instr = NOP; e_fault = 1'b0;
                end else if ((a % 4) != 0 || a >= 4 * DEPTH) begin
                    e_instr = NOP; e_fault = 1'b1;
                end else if (a / 4 < prog.size()) begin
                    e_instr = prog[a / 4]; e_fault = 1'b0;
                end else begin
                    e_instr = NOP; e_fault = 1'b0;
                end
            end
        end
        e_done = 1'b0;
        if (m_mode == 1) begin
            if (bus.ld_valid && prog.size() < DEPTH) begin
                prog.push_back(bus.ld_data);
                if (bus.ld_last || prog.size() == DEPTH) begin
                    m_mode = 2;
                    e_done = 1'b1;
                end
            end
        end else if (bus.ld_start) begin
            m_mode = 1;
            prog.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(string tag);
        logic e_rdy;
        e_rdy = (m_mode == 1) && (prog.size() < DEPTH);
        chk({tag, ".valid"}, bus.if_valid, e_valid);
        chk({tag, ".instr"}, bus.if_instr, e_instr);
        chk({tag, ".fault"}, bus.if_fault, e_fault);
        chk({tag, ".done"},  bus.ld_done,  e_done);
        chk({tag, ".count"}, bus.ld_count, prog.size());
        chk({tag, ".ready"}, bus.ld_ready, e_rdy);
    endtask

    task automatic apply_reset(string tag);
        idle_inputs();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk({tag, ".valid"}, bus.if_valid, 0);
        chk({tag, ".instr"}, bus.if_instr, NOP);
        chk({tag, ".fault"}, bus.if_fault, 0);
        chk({tag, ".ready"}, bus.ld_ready, 0);
        chk({tag, ".done"},  bus.ld_done,  0);
        chk({tag, ".count"}, bus.ld_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(logic [31:0] data, logic last);
        chk("ld_ready_before_word", bus.ld_ready, 1);
        bus.ld_valid = 1'b1;
        bus.ld_data  = data;
        bus.ld_last  = last;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic fetch(logic [31:0] addr, logic [31:0] exp_instr, logic exp_fault, string tag);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        tick();
        bus.if_req  = 1'b0;
        chk({tag, ".valid"}, bus.if_valid, 1);
        chk({tag, ".instr"}, bus.if_instr, exp_instr);
        chk({tag, ".fault"}, bus.if_fault, exp_fault);
    endtask

    initial begin
        tbl[0] = '{32'h0000_0000, 32'h00500093, 1'b0};
        tbl[1] = '{32'h0000_0004, 32'h00A00113, 1'b0};
        tbl[2] = '{32'h0000_0008, 32'h002081B3, 1'b0};
        tbl[3] = '{32'h0000_000C, NOP,          1'b0};
        tbl[4] = '{32'h0000_0006, NOP,          1'b1};
        tbl[5] = '{32'h0000_0100, NOP,          1'b1};
        tbl[6] = '{32'h0000_00FC, NOP,          1'b0};
        tbl[7] = '{32'hFFFF_FFFC, NOP,          1'b1};

        #1;
        apply_reset("reset");

        // three-word load ending on ld_last
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        chk("count_on_load_entry", bus.ld_count, 0);
        load_word(32'h00500093, 1'b0);
        chk("done_w0", bus.ld_done, 0);
        load_word(32'h00A00113, 1'b0);
        chk("done_w1", bus.ld_done, 0);
        load_word(32'h002081B3, 1'b1);
        chk("done_w2", bus.ld_done, 1);
        chk("count_w2", bus.ld_count, 3);
        chk("ready_in_run", bus.ld_ready, 0);
        tick();
        chk("done_single_pulse", bus.ld_done, 0);

        // fetch table: hits, unloaded NOP fill, misaligned and out-of-range faults
        for (int i = 0; i < 8; i++) begin
            bus.if_req  = 1'b1;
            bus.if_addr = tbl[i].addr;
            tick();
            chk($sformatf("tbl%0d.valid", i), bus.if_valid, 1);
            chk($sformatf("tbl%0d.instr", i), bus.if_instr, tbl[i].instr);
            chk($sformatf("tbl%0d.fault", i), bus.if_fault, tbl[i].fault);
        end
        bus.if_req = 1'b0;
        tick();
        chk("noreq.valid", bus.if_valid, 0);
        chk("noreq.instr_held", bus.if_instr, NOP);
        chk("noreq.fault_held", bus.if_fault, 1);

        // stall freezes the response while address and request change
        fetch(32'h4, 32'h00A00113, 1'b0, "prestall");
        bus.if_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.if_req  = k[0];
            bus.if_addr = 32'h8 + 32'(k) * 4;
            tick();
            chk($sformatf("stall%0d.valid", k), bus.if_valid, 1);
            chk($sformatf("stall%0d.instr", k), bus.if_instr, 32'h00A00113);
        end
        bus.if_stall = 1'b0;
        fetch(32'h8, 32'h002081B3, 1'b0, "poststall");

        // reload from RUN: same-cycle fetch sees the old program
        bus.ld_start = 1'b1;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h0;
        tick();
        bus.ld_start = 1'b0;
        bus.if_req   = 1'b0;
        chk("reload_fetch.instr", bus.if_instr, 32'h00500093);
        chk("reload.count", bus.ld_count, 0);
        fetch(32'h0, NOP, 1'b0, "load_fetch");
        fetch(32'h6, NOP, 1'b0, "load_fetch_mis");

        // ld_start during LOAD is ignored, then fill all 64 words without ld_last
        bus.ld_start = 1'b1;
        load_word(32'hA000_0000, 1'b0);
        bus.ld_start = 1'b0;
        chk("start_in_load.count", bus.ld_count, 1);
        for (int i = 1; i < DEPTH; i++) begin
            load_word(32'hA000_0000 + 32'(i), 1'b0);
        end
        chk("full.done", bus.ld_done, 1);
        chk("full.count", bus.ld_count, DEPTH);
        chk("full.ready", bus.ld_ready, 0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'hDEAD_BEEF;
        tick();
        bus.ld_valid = 1'b0;
        chk("extra.count", bus.ld_count, DEPTH);
        chk("extra.done", bus.ld_done, 0);
        fetch(32'hFC, 32'hA000_003F, 1'b0, "full_last");
        fetch(32'h0, 32'hA000_0000, 1'b0, "full_first");

        // reset mid-load, then a one-word reload
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        load_word(32'h1111_1111, 1'b0);
        load_word(32'h2222_2222, 1'b0);
        bus.if_req = 1'b1;
        apply_reset("midreset");
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        load_word(32'h3333_3333, 1'b1);
        chk("reload1.count", bus.ld_count, 1);
        fetch(32'h4, NOP, 1'b0, "after_reset_w1");
        fetch(32'h0, 32'h3333_3333, 1'b0, "after_reset_w0");

        // randomized traffic against the reference model
        check_model("sync");
        for (int c = 0; c < 3000; c++) begin
            bus.ld_start = ($urandom_range(0, 39) == 0);
            bus.ld_valid = $urandom_range(0, 1);
            bus.ld_data  = $urandom;
            bus.ld_last  = bus.ld_valid && ($urandom_range(0, 7) == 0);
            bus.if_req   = ($urandom_range(0, 3) != 0);
            bus.if_stall = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       bus.if_addr = $urandom_range(0, DEPTH - 1) * 4;
                1:       bus.if_addr = $urandom_range(0, 4 * DEPTH - 1);
                2:       bus.if_addr = $urandom;
                default: bus.if_addr = $urandom_range(0, 7) * 4;
            endcase
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, synchronous instruction memory for the RISC-V pipelined core. It sits between the IF stage and a program-loader source (testbench, UART bridge or debug port). The loader writes a program word-by-word through a valid/ready handshake. IF then fetches through a one-cycle registered read port with stall hold, misalignment/range fault detection and NOP fill for unloaded words.

## Interface
Parameters:
- XLEN, 32, instruction/data word width in bits
- DEPTH, 64, number of words; power of two, at least 4
- AW, 32, width of the byte address supplied by IF
- NOP, 32'h00000013, word returned for fault, unloaded or non-running fetches (addi x0,x0,0)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, sampled on clk
- if_addr  in  AW  fetch byte address (PC)
- if_stall  in  1  hold the fetch output registers
- if_valid  out  1  if_instr holds a response
- if_instr  out  XLEN  fetched instruction
- if_fault  out  1  the response is for a misaligned or out-of-range address
- ld_start  in  1  begin a (re)load at word 0
- ld_valid  in  1  ld_data is valid
- ld_data  in  XLEN  program word
- ld_last  in  1  qualifies the final word, valid only with ld_valid
- ld_ready  out  1  the block accepts ld_data this cycle
- ld_done  out  1  one-cycle pulse when the load completes
- ld_count  out  $clog2(DEPTH)+1  number of words currently loaded

## Operation
- Storage: reg array [0:DEPTH-1] of XLEN bits.
  - Reset does not clear the array.
  - Validity is tracked only by ld_count; any word at index >= ld_count reads as NOP with no fault.
- FSM states:
  - IDLE: state after reset. ld_start moves to LOAD.
  - LOAD: ld_ready=1 while wptr<DEPTH.
    - Each ld_valid&&ld_ready writes mem[wptr] and increments wptr and ld_count.
    - The FSM moves to RUN after the accepted word has ld_last=1, or after the accepted word that makes wptr==DEPTH.
    - On that transition, ld_done pulses for one cycle.
    - ld_start while in LOAD is ignored.
  - RUN: fetches are served. ld_start moves to LOAD.
- LOAD entry, from IDLE or RUN: wptr=0 and ld_count=0. A reload therefore invalidates the old program immediately.
- Fetch index: idx = if_addr[$clog2(DEPTH)+1:2].
- Fault condition: if_addr[1:0]!=0, or any if_addr bit above bit $clog2(DEPTH)+1 is set. On a fault, if_fault=1 and if_instr=NOP.
- Fetch responses by state:
  - IDLE or LOAD: if_req yields if_valid=1, if_instr=NOP, if_fault=0. This lets the core spin safely.
  - RUN: if_instr=mem[idx] when idx<ld_count, otherwise NOP.
- Fault has priority over the NOP fill rule.

## Timing
- Reset values: if_valid=0, if_instr=NOP, if_fault=0, ld_ready=0, ld_done=0, ld_count=0, state=IDLE, wptr=0.
- Read latency is 1 cycle: if_req at edge N produces if_valid, if_instr and if_fault after edge N, stable until edge N+1.
- if_stall=1 holds if_valid, if_instr and if_fault unchanged, and if_req is ignored. Stall has priority over the request.
- With if_req=0 and no stall, if_valid=0 on the next cycle, and if_instr/if_fault keep their last values.
- Write-then-read in the same cycle cannot occur: fetches return NOP during LOAD. The first RUN cycle sees every written word.
- ld_ready is combinational from the state and wptr. ld_done is registered and is high during the first RUN cycle.
- Asserting rst_n low mid-load goes straight to IDLE and sets ld_count=0. Partially written words become unreadable (NOP).
- Cycle where ld_start arrives in RUN together with if_req: the fetch is served with the pre-reload contents. LOAD begins the next cycle.

## Test plan
- Reset, ld_start, then 3 words 0x00500093, 0x00A00113, 0x002081B3 with ld_last on the 3rd -> ld_done pulses once, ld_count=3. Fetches at 0x0, 0x4, 0x8 each return the corresponding word 1 cycle later with if_valid=1.
- Fetch at 0xC after that 3-word load -> if_instr=0x00000013, if_fault=0. Fetch at 0x6 -> NOP with if_fault=1. Fetch at 0x100 with DEPTH=64 -> NOP with if_fault=1.
- Load 64 words with no ld_last -> ld_ready drops after word 64, the FSM moves to RUN, ld_done pulses. A 65th ld_valid is not accepted.
- Hold if_stall=1 for 3 cycles while if_addr changes -> if_instr and if_valid stay frozen at the pre-stall response. When the stall releases, the new address responds 1 cycle later.
- Drive rst_n low after 2 of 5 words -> all outputs return to their reset values. After ld_start and a 1-word reload, fetch at 0x4 returns NOP.
- In RUN, ld_start -> ld_count=0 the next cycle. Fetches during LOAD return NOP with if_valid=1 and if_fault=0.
